// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine holding results in architectural HI/LO.
// Operands are reduced to magnitudes on accept and signs are reapplied in FIX.
//   state | meaning
//   IDLE  | waiting for start_i; MTHI/MTLO writes accepted here
//   CALC  | one shift-add or restoring-divide step per cycle, WIDTH cycles
//   FIX   | sign correction, HI/LO write, done_o pulse
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic             mthi_i,
    input  logic             mtlo_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             div_zero_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t             state, state_nxt;
    logic               is_div, neg_q, neg_r;
    logic               dz_pend, done_r, dz_r;
    logic [WIDTH-1:0]   opb, hi_r, lo_r;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;

    logic               busy, accept, div_by_zero;
    logic               src1_neg, src2_neg;
    logic [WIDTH-1:0]   mag1, mag2;
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] step_acc, prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix;

    always_comb begin
        busy        = (state != IDLE) || dz_pend;
        accept      = start_i && !busy;
        div_by_zero = op_i[1] && (src2_i == '0);

        src1_neg = !op_i[0] && src1_i[WIDTH-1];
        src2_neg = !op_i[0] && src2_i[WIDTH-1];
        mag1     = src1_neg ? -src1_i : src1_i;
        mag2     = src2_neg ? -src2_i : src2_i;

        // mul: acc = {partial product, remaining multiplier bits}
        // div: acc = {partial remainder, remaining dividend / quotient bits}
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, opb};
        div_diff  = div_shift - {1'b0, opb};

        if (!is_div)
            step_acc = {mul_sum, acc[WIDTH-1:1]};
        else if (div_ge)
            step_acc = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        else
            step_acc = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};

        prod_fix = neg_q ? -acc : acc;
        quot_fix = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && !div_by_zero) state_nxt = CALC;
            CALC:    if (cnt == '0) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            is_div  <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            dz_pend <= 1'b0;
            done_r  <= 1'b0;
            dz_r    <= 1'b0;
            opb     <= '0;
            acc     <= '0;
            cnt     <= '0;
            hi_r    <= '0;
            lo_r    <= '0;
        end else begin
            done_r  <= 1'b0;
            dz_pend <= 1'b0;
            if (dz_pend) begin
                done_r <= 1'b1;
                dz_r   <= 1'b1;
            end
            if (accept) begin
                is_div  <= op_i[1];
                neg_q   <= src1_neg ^ src2_neg;
                neg_r   <= src1_neg;
                opb     <= op_i[1] ? mag2 : mag1;
                acc     <= {{WIDTH{1'b0}}, (op_i[1] ? mag1 : mag2)};
                cnt     <= CW'(WIDTH - 1);
                dz_r    <= 1'b0;
                dz_pend <= div_by_zero;
            end else if (!busy) begin
                if (mthi_i) hi_r <= src1_i;
                if (mtlo_i) lo_r <= src1_i;
            end
            if (state == CALC) begin
                acc <= step_acc;
                cnt <= cnt - 1'b1;
            end
            if (state == FIX) begin
                done_r <= 1'b1;
                if (is_div) begin
                    hi_r <= rem_fix;
                    lo_r <= quot_fix;
                end else begin
                    hi_r <= prod_fix[2*WIDTH-1:WIDTH];
                    lo_r <= prod_fix[WIDTH-1:0];
                end
            end
        end
    end

    assign busy_o     = busy;
    assign done_o     = done_r;
    assign div_zero_o = dz_r;
    assign hi_o       = hi_r;
    assign lo_o       = lo_r;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: arithmetic reference model checked every
// cycle, plus literal expectations for the documented corner cases.
module tb_mul_div_unit;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic [1:0]  op_i = 2'b00;
    logic [31:0] src1_i = '0;
    logic [31:0] src2_i = '0;
    logic        mthi_i = 1'b0;
    logic        mtlo_i = 1'b0;
    logic        busy_o, done_o, div_zero_o;
    logic [31:0] hi_o, lo_o;

    int checks = 0;
    int errors = 0;

    mul_div_unit #(.WIDTH(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .op_i(op_i),
        .src1_i(src1_i), .src2_i(src2_i), .mthi_i(mthi_i), .mtlo_i(mtlo_i),
        .busy_o(busy_o), .done_o(done_o), .div_zero_o(div_zero_o),
        .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model_res(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa, sb, q, r;
        longint unsigned ua, ub, uq, ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        model_res = '0;
        case (op)
            2'd0: model_res = sa * sb;
            2'd1: model_res = ua * ub;
            2'd2: begin
                q = sa / sb;
                r = sa % sb;
                model_res = {r[31:0], q[31:0]};
            end
            default: begin
                uq = ua / ub;
                ur = ua % ub;
                model_res = {ur[31:0], uq[31:0]};
            end
        endcase
    endfunction

    // Reference model: countdown of remaining cycles, result committed at the end.
    int          m_cnt = 0;
    logic        m_dzpend = 1'b0, m_done = 1'b0, m_dz = 1'b0;
    logic [31:0] m_hi = '0, m_lo = '0;
    logic [63:0] m_pend = '0;

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            m_cnt = 0; m_dzpend = 0; m_done = 0; m_dz = 0; m_hi = '0; m_lo = '0;
        end else begin
            m_done = 0;
            if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    {m_hi, m_lo} = m_pend;
                    m_done = 1;
                end
            end else if (m_dzpend) begin
                m_dzpend = 0;
                m_done = 1;
                m_dz = 1;
            end else if (start_i) begin
                m_dz = 0;
                if (op_i[1] && src2_i == 0) m_dzpend = 1;
                else begin
                    m_pend = model_res(op_i, src1_i, src2_i);
                    m_cnt = 33;
                end
            end else begin
                if (mthi_i) m_hi = src1_i;
                if (mtlo_i) m_lo = src1_i;
            end
        end
    end

    always begin
        @(posedge clk_i);
        #1;
        if (!rst_i) begin
            chk("cyc_busy", {31'b0, busy_o}, {31'b0, (m_cnt > 0) || m_dzpend});
            chk("cyc_done", {31'b0, done_o}, {31'b0, m_done});
            chk("cyc_divzero", {31'b0, div_zero_o}, {31'b0, m_dz});
            chk("cyc_hi", hi_o, m_hi);
            chk("cyc_lo", lo_o, m_lo);
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        op_i = op; src1_i = a; src2_i = b; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        src1_i = $urandom;
        src2_i = $urandom;
    endtask

    task automatic wait_done(input int exp_cyc, input string name);
        int n = 0;
        bit seen = 0;
        while (n < 40 && !seen) begin
            tick();
            n++;
            if (done_o) seen = 1;
        end
        chk({name, "_done_seen"}, {31'b0, seen}, 32'd1);
        if (seen) chk({name, "_latency"}, n, exp_cyc);
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el, input string name);
        logic [63:0] mr;
        mr = model_res(op, a, b);
        chk({name, "_model_hi"}, mr[63:32], eh);
        chk({name, "_model_lo"}, mr[31:0], el);
        start_op(op, a, b);
        wait_done(33, name);
        chk({name, "_hi"}, hi_o, eh);
        chk({name, "_lo"}, lo_o, el);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int got;
        repeat (3) tick();
        chk("rst_busy", {31'b0, busy_o}, 32'd0);
        chk("rst_done", {31'b0, done_o}, 32'd0);
        chk("rst_hi", hi_o, 32'h0);
        chk("rst_lo", lo_o, 32'h0);
        rst_i = 1'b0;
        tick();

        run_op(2'd0, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, "mult_neg");
        run_op(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu_max");
        run_op(2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, "mult_m1");
        run_op(2'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, "mult_min");
        run_op(2'd0, 32'hFFFFFFFB, 32'hFFFFFFFA, 32'h00000000, 32'd30,       "mult_negneg");
        run_op(2'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg");
        run_op(2'd3, 32'd7,        32'd2,        32'd1,        32'd3,        "divu_small");
        run_op(2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div_ovf");
        run_op(2'd2, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, "div_negdiv");
        run_op(2'd3, 32'hFFFFFFFF, 32'h10,       32'hF,        32'h0FFFFFFF, "divu_big");

        src1_i = 32'd5; mthi_i = 1'b1; mtlo_i = 1'b1;
        tick();
        mthi_i = 1'b0; mtlo_i = 1'b0;
        chk("mt_hi", hi_o, 32'd5);
        chk("mt_lo", lo_o, 32'd5);
        start_op(2'd2, 32'd9, 32'd0);
        wait_done(1, "div0");
        chk("div0_flag", {31'b0, div_zero_o}, 32'd1);
        chk("div0_busy", {31'b0, busy_o}, 32'd0);
        chk("div0_hi", hi_o, 32'd5);
        chk("div0_lo", lo_o, 32'd5);
        start_op(2'd0, 32'd2, 32'd3);
        chk("dz_cleared", {31'b0, div_zero_o}, 32'd0);
        wait_done(33, "mul_after_dz");
        chk("mul_after_dz_hi", hi_o, 32'd0);
        chk("mul_after_dz_lo", lo_o, 32'd6);

        start_op(2'd0, 32'd3, 32'd4);
        repeat (9) tick();
        op_i = 2'd3; src1_i = 32'd8; src2_i = 32'd2; start_i = 1'b1; mthi_i = 1'b1;
        tick();
        start_i = 1'b0; mthi_i = 1'b0;
        wait_done(23, "busy_ignore");
        chk("busy_ignore_hi", hi_o, 32'd0);
        chk("busy_ignore_lo", lo_o, 32'd12);
        src1_i = 32'hA5; mtlo_i = 1'b1;
        tick();
        mtlo_i = 1'b0;
        chk("mtlo_a5", lo_o, 32'hA5);
        chk("mtlo_a5_hi", hi_o, 32'd0);

        start_op(2'd2, 32'd100, 32'd3);
        repeat (14) tick();
        rst_i = 1'b1;
        #1;
        chk("abort_busy", {31'b0, busy_o}, 32'd0);
        chk("abort_done", {31'b0, done_o}, 32'd0);
        chk("abort_hi", hi_o, 32'd0);
        chk("abort_lo", lo_o, 32'd0);
        tick();
        rst_i = 1'b0;
        got = 0;
        repeat (35) begin
            tick();
            if (done_o) got = 1;
        end
        chk("abort_no_done", got, 0);
        run_op(2'd3, 32'd100, 32'd7, 32'd2, 32'd14, "divu_after_rst");

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
